// File: rtl/fft_pkg.sv
// Shared definitions for the 4-point FFT frame arbiter: state encoding,
// frame length and sample width.
package fft_pkg;
  localparam int SAMPLE_W  = 8;
  localparam int FRAME_LEN = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLR    = 2'd1,
    S_STREAM = 2'd2,
    S_WAIT   = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the channel not granted last wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = i_last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/fft4_frame_arb.sv
// Shares one 4-point FFT core between two sample channels, one whole frame
// per grant, with a bounded wait for the core's result.
module fft4_frame_arb
  import fft_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int FRAME_LEN   = fft_pkg::FRAME_LEN,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             s_valid,
  output logic [NCH-1:0]             s_ready,
  input  logic signed [SAMPLE_W-1:0] s0_xr,
  input  logic signed [SAMPLE_W-1:0] s0_xi,
  input  logic signed [SAMPLE_W-1:0] s1_xr,
  input  logic signed [SAMPLE_W-1:0] s1_xi,
  output logic                       core_clr,
  output logic                       core_valid_in,
  output logic signed [SAMPLE_W-1:0] core_xr,
  output logic signed [SAMPLE_W-1:0] core_xi,
  input  logic                       core_done,
  output logic                       out_valid,
  output logic                       out_ch,
  output logic [7:0]                 out_seq,
  output logic                       err_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t                     r_state;
  logic [NCH-1:0]             r_gnt_oh;
  logic                       r_last;
  logic [2:0]                 r_cnt;
  logic [TW-1:0]              r_tmo;
  logic [7:0]                 r_seq;
  logic [NCH-1:0]             r_s_ready;
  logic                       r_core_clr;
  logic                       r_core_vld;
  logic signed [SAMPLE_W-1:0] r_xr;
  logic signed [SAMPLE_W-1:0] r_xi;
  logic                       r_out_valid;
  logic                       r_out_ch;
  logic [7:0]                 r_out_seq;
  logic                       r_err;

  logic [1:0]                 w_gnt;
  logic                       w_grant;
  logic                       w_acc;
  logic signed [SAMPLE_W-1:0] w_xr;
  logic signed [SAMPLE_W-1:0] w_xi;

  rr_arb2 u_arb (
    .i_req  (s_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_grant = r_gnt_oh[1];
  assign w_acc   = (r_state == S_STREAM) && |(s_valid & r_s_ready);
  assign w_xr    = w_grant ? s1_xr : s0_xr;
  assign w_xi    = w_grant ? s1_xi : s0_xi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt_oh    <= '0;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_seq       <= '0;
      r_s_ready   <= '0;
      r_core_clr  <= 1'b0;
      r_core_vld  <= 1'b0;
      r_xr        <= '0;
      r_xi        <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= 1'b0;
      r_out_seq   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_core_clr  <= 1'b0;
      r_out_valid <= 1'b0;
      r_core_vld  <= w_acc;
      if (w_acc) begin
        r_xr <= w_xr;
        r_xi <= w_xi;
      end
      case (r_state)
        S_IDLE: if (|s_valid) begin
          r_gnt_oh   <= w_gnt;
          r_core_clr <= 1'b1;
          r_state    <= S_CLR;
        end
        S_CLR: begin
          r_s_ready <= r_gnt_oh;
          r_cnt     <= '0;
          r_state   <= S_STREAM;
        end
        S_STREAM: if (w_acc) begin
          if (r_cnt == 3'(FRAME_LEN - 1)) begin
            r_cnt     <= '0;
            r_s_ready <= '0;
            r_tmo     <= '0;
            r_state   <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still counts as done.
          if (core_done) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= w_grant;
            r_out_seq   <= r_seq;
            r_seq       <= r_seq + 8'd1;
            r_last      <= w_grant;
            r_state     <= S_IDLE;
          end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
            r_err   <= 1'b1;
            r_last  <= w_grant;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready       = r_s_ready;
  assign core_clr      = r_core_clr;
  assign core_valid_in = r_core_vld;
  assign core_xr       = r_xr;
  assign core_xi       = r_xi;
  assign out_valid     = r_out_valid;
  assign out_ch        = r_out_ch;
  assign out_seq       = r_out_seq;
  assign err_timeout   = r_err;
endmodule

// File: tb/tb_fft4_frame_arb.sv
// Bench for fft4_frame_arb: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fft4_frame_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] s_valid = 2'b00;
  logic signed [7:0] s0_xr = 0, s0_xi = 0, s1_xr = 0, s1_xi = 0;
  logic [1:0] s_ready;
  logic core_clr, core_valid_in;
  logic signed [7:0] core_xr, core_xi;
  logic r_resp = 1'b0, r_poke = 1'b0;
  logic core_done;
  logic out_valid, out_ch;
  logic [7:0] out_seq;
  logic err_timeout;

  assign core_done = r_resp | r_poke;
  always #5 clk = ~clk;

  fft4_frame_arb dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s0_xr(s0_xr), .s0_xi(s0_xi), .s1_xr(s1_xr), .s1_xi(s1_xi),
    .core_clr(core_clr), .core_valid_in(core_valid_in),
    .core_xr(core_xr), .core_xi(core_xi), .core_done(core_done),
    .out_valid(out_valid), .out_ch(out_ch), .out_seq(out_seq),
    .err_timeout(err_timeout)
  );

  int ncmp = 0, nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: who owns the core, how far the frame has got, and how
  // long we have waited for the result.
  localparam int M_IDLE = 0, M_CLR = 1, M_STREAM = 2, M_WAIT = 3;
  int m_mode = M_IDLE, m_own = 0, m_got = 0, m_waited = 0, m_last = 1, m_seq = 0;
  logic chk_on = 1'b0;
  logic e_clr = 0, e_vld = 0, e_ov = 0, e_ch = 0, e_err = 0;
  logic [1:0] e_rdy = 2'b00;
  logic signed [7:0] e_xr = 0, e_xi = 0;
  logic [7:0] e_seq = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_own = 0; m_got = 0; m_waited = 0; m_last = 1; m_seq = 0;
      e_clr = 0; e_vld = 0; e_ov = 0; e_ch = 0; e_err = 0; e_rdy = 2'b00;
      e_xr = 0; e_xi = 0; e_seq = 0;
    end else begin
      e_clr = 0; e_vld = 0; e_ov = 0;
      case (m_mode)
        M_IDLE: if (s_valid != 2'b00) begin
          if (s_valid == 2'b11) m_own = (m_last == 1) ? 0 : 1;
          else m_own = s_valid[1] ? 1 : 0;
          e_clr = 1; m_mode = M_CLR;
        end
        M_CLR: begin
          e_rdy = (m_own == 1) ? 2'b10 : 2'b01; m_got = 0; m_mode = M_STREAM;
        end
        M_STREAM: if (s_valid[m_own]) begin
          e_vld = 1;
          e_xr = (m_own == 1) ? s1_xr : s0_xr;
          e_xi = (m_own == 1) ? s1_xi : s0_xi;
          m_got++;
          if (m_got == 4) begin e_rdy = 2'b00; m_waited = 0; m_mode = M_WAIT; end
        end
        default: begin
          if (core_done) begin
            e_ov = 1; e_ch = m_own[0]; e_seq = 8'(m_seq);
            m_seq = (m_seq + 1) % 256; m_last = m_own; m_mode = M_IDLE;
          end else begin
            m_waited++;
            if (m_waited == 16) begin e_err = 1; m_last = m_own; m_mode = M_IDLE; end
          end
        end
      endcase
    end
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("core_clr", int'(core_clr), int'(e_clr));
      chk("core_valid_in", int'(core_valid_in), int'(e_vld));
      if (e_vld) begin
        chk("core_xr", int'(core_xr), int'(e_xr));
        chk("core_xi", int'(core_xi), int'(e_xi));
      end
      chk("s_ready", int'(s_ready), int'(e_rdy));
      chk("out_valid", int'(out_valid), int'(e_ov));
      chk("out_ch", int'(out_ch), int'(e_ch));
      chk("out_seq", int'(out_seq), int'(e_seq));
      chk("err_timeout", int'(err_timeout), int'(e_err));
    end
  end

  // Observation log used by the directed scenarios.
  int cyc = 0;
  always @(posedge clk) cyc++;
  int stb_xr[$], stb_xi[$], ov_ch_q[$], ov_seq_q[$];
  int nclr = 0, last_stb_cyc = 0, err_cyc = -1, both_rdy = 0;
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    if (core_valid_in) begin
      stb_xr.push_back(int'(core_xr)); stb_xi.push_back(int'(core_xi)); last_stb_cyc = cyc;
    end
    if (core_clr) nclr++;
    if (out_valid) begin ov_ch_q.push_back(int'(out_ch)); ov_seq_q.push_back(int'(out_seq)); end
    if (err_timeout && !prev_err) err_cyc = cyc;
    prev_err = err_timeout;
    if (s_ready == 2'b11) both_rdy++;
  end

  // Core stand-in: answers resp_dly cycles after the 4th strobe of a frame.
  int resp_dly = 3;
  logic resp_en = 1'b1;
  initial begin : responder
    int nstb;
    nstb = 0;
    forever begin
      @(negedge clk);
      if (core_clr || rst) nstb = 0;
      if (core_valid_in) nstb++;
      if (core_valid_in && nstb == 4) begin
        nstb = 0;
        if (resp_en) begin
          repeat (resp_dly) @(posedge clk);
          #1 r_resp = 1'b1;
          @(posedge clk); #1 r_resp = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int ch, input int xr, input int xi);
    int n;
    n = 0;
    if (ch == 0) begin s0_xr = 8'(xr); s0_xi = 8'(xi); end
    else begin s1_xr = 8'(xr); s1_xi = 8'(xi); end
    s_valid[ch] = 1'b1;
    while (s_ready[ch] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n == 64) chk("push_ready", int'(s_ready[ch]), 1);
    @(posedge clk); #1;
    s_valid[ch] = 1'b0;
  endtask

  task automatic wait_ov(input int target, input int budget);
    int n;
    n = 0;
    while (ov_ch_q.size() < target && n < budget) begin @(posedge clk); n++; end
    #1;
    if (ov_ch_q.size() < target) chk("out_valid_wait", ov_ch_q.size(), target);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : main
    int exr[4], exi[4], gch[3], b_stb, b_clr, b_ov, n;
    exr = '{100, 71, 0, -71};
    exi = '{0, 71, 100, 71};
    gch = '{0, 1, 0};
    tick(3); rst = 1'b0; tick(2);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_out_seq", int'(out_seq), 0);
    chk("rst_err", int'(err_timeout), 0);

    // Single channel 0 frame, core answers 3 cycles after the 4th strobe.
    b_stb = stb_xr.size(); b_clr = nclr; b_ov = ov_ch_q.size();
    for (int i = 0; i < 4; i++) push(0, exr[i], exi[i]);
    wait_ov(b_ov + 1, 40);
    chk("t1_strobes", stb_xr.size() - b_stb, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_xr", stb_xr[b_stb + i], exr[i]);
      chk("t1_xi", stb_xi[b_stb + i], exi[i]);
    end
    chk("t1_clr", nclr - b_clr, 1);
    chk("t1_ch", ov_ch_q[b_ov], 0);
    chk("t1_seq", ov_seq_q[b_ov], 0);

    // Both channels requesting continuously for three frames.
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    b_stb = stb_xr.size(); b_ov = ov_ch_q.size();
    s0_xr = 10; s0_xi = -10; s1_xr = 20; s1_xi = -20; s_valid = 2'b11;
    n = 0;
    while (stb_xr.size() < b_stb + 12 && n < 200) begin @(negedge clk); n++; end
    s_valid = 2'b00;
    wait_ov(b_ov + 3, 60);
    for (int i = 0; i < 3; i++) begin
      chk("t2_ch", ov_ch_q[b_ov + i], gch[i]);
      chk("t2_seq", ov_seq_q[b_ov + i], i);
    end
    chk("t2_ready_both", both_rdy, 0);

    // Channel 1 with a 5-cycle gap after the second sample.
    b_stb = stb_xr.size(); b_ov = ov_ch_q.size();
    push(1, 5, 6); push(1, 7, 8); tick(5); push(1, 9, 10); push(1, 11, 12);
    wait_ov(b_ov + 1, 40);
    chk("t3_strobes", stb_xr.size() - b_stb, 4);
    chk("t3_ch", ov_ch_q[b_ov], 1);
    chk("t3_seq", ov_seq_q[b_ov], 3);
    chk("t3_err", int'(err_timeout), 0);

    // Result on the very last cycle of the wait window beats the timeout.
    resp_dly = 15; b_ov = ov_ch_q.size();
    for (int i = 0; i < 4; i++) push(0, i, -i);
    wait_ov(b_ov + 1, 40);
    chk("prio_seq", ov_seq_q[b_ov], 4);
    chk("prio_err", int'(err_timeout), 0);
    resp_dly = 3;

    // Core never answers: timeout, then a normal frame.
    resp_en = 1'b0; b_ov = ov_ch_q.size();
    for (int i = 0; i < 4; i++) push(1, 30 + i, 40 + i);
    n = 0;
    while (err_timeout !== 1'b1 && n < 40) begin tick(1); n++; end
    tick(2);
    chk("t4_err", int'(err_timeout), 1);
    chk("t4_err_latency", err_cyc - last_stb_cyc, 16);
    chk("t4_no_ov", ov_ch_q.size() - b_ov, 0);
    resp_en = 1'b1;
    for (int i = 0; i < 4; i++) push(0, 50 + i, 60 + i);
    wait_ov(b_ov + 1, 40);
    chk("t4_next_ch", ov_ch_q[b_ov], 0);
    chk("t4_next_seq", ov_seq_q[b_ov], 5);
    chk("t4_err_sticky", int'(err_timeout), 1);

    // Reset after the second sample aborts the frame.
    b_ov = ov_ch_q.size();
    push(0, 1, 2); push(0, 3, 4);
    rst = 1'b1; tick(1); rst = 1'b0; tick(2);
    chk("t5_ready", int'(s_ready), 0);
    chk("t5_vld", int'(core_valid_in), 0);
    chk("t5_err", int'(err_timeout), 0);
    chk("t5_no_ov", ov_ch_q.size() - b_ov, 0);
    b_clr = nclr;
    for (int i = 0; i < 4; i++) push(0, -5 - i, 5 + i);
    wait_ov(b_ov + 1, 40);
    chk("t5_clr", nclr - b_clr, 1);
    chk("t5_seq", ov_seq_q[b_ov], 0);

    // Stray core_done in IDLE and mid-STREAM.
    b_ov = ov_ch_q.size();
    r_poke = 1'b1; tick(1); r_poke = 1'b0; tick(1);
    push(0, 1, 1); push(0, 2, 2);
    r_poke = 1'b1; tick(1); r_poke = 1'b0;
    push(0, 3, 3); push(0, 4, 4);
    wait_ov(b_ov + 1, 40);
    tick(5);
    chk("t6_ov_count", ov_ch_q.size() - b_ov, 1);
    chk("t6_seq", ov_seq_q[b_ov], 1);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/fft4_frame_arb.md
FFT4_FRAME_ARB -- requirements
Module: fft4_frame_arb

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning the number of requesting sample channels (fixed at 2 in this revision).
REQ-002 SHALL have parameter FRAME_LEN, default 4, meaning the samples per FFT frame, matched to the 4-point core.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum number of cycles WAIT may last before abort.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports s_valid, input, 2 bits: per-channel sample valid.
REQ-007 SHALL have ports s_ready, output, 2 bits: per-channel sample ready.
REQ-008 SHALL have ports s0_xr, s0_xi, s1_xr, s1_xi, input, 8 bits signed each: per-channel real and imaginary samples.
REQ-009 SHALL have ports core_clr, output, 1 bit: a one-cycle pulse that clears the shared core's sample counter before each frame.
REQ-010 SHALL have port core_valid_in, output, 1 bit: sample strobe to the core.
REQ-011 SHALL have ports core_xr, core_xi, output, 8 bits signed: sample data to the core.
REQ-012 SHALL have port core_done, input, 1 bit: the core's result-valid pulse.
REQ-013 SHALL have port out_valid, output, 1 bit: pulse marking that the core results belong to out_ch.
REQ-014 SHALL have port out_ch, output, 1 bit: channel owning the completed frame.
REQ-015 SHALL have port out_seq, output, 8 bits: per-grant frame sequence number, wrapping 255 to 0.
REQ-016 SHALL have port err_timeout, output, 1 bit: sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, CLR, STREAM and WAIT.
REQ-018 In IDLE, SHALL grant the requesting channel (s_valid high) using round-robin against last_grant; if both request, the channel not granted last wins; with no request, SHALL stay in IDLE.
REQ-019 On a grant, SHALL latch grant_ch and move IDLE->CLR; CLR SHALL assert core_clr for exactly 1 cycle and then go to STREAM.
REQ-020 In STREAM, s_ready[grant_ch] SHALL be 1 and the other s_ready bit SHALL be 0; a sample is accepted when s_valid and s_ready are both high.
REQ-021 SHALL register each accepted sample to core_xr/core_xi with core_valid_in=1 one cycle later, giving 1 cycle of sample latency.
REQ-022 If s_valid drops mid-frame, SHALL hold core_valid_in=0 and keep the sample count, with no timeout in STREAM.
REQ-023 After FRAME_LEN accepted samples (3-bit counter 0..4), SHALL go STREAM->WAIT; s_ready SHALL be 0 in WAIT.
REQ-024 In WAIT, SHALL pulse out_valid for 1 cycle on core_done, with out_ch=grant_ch and out_seq=current sequence, then increment the sequence, update last_grant, and return to IDLE.
REQ-025 If core_done has not arrived after TIMEOUT_CYC cycles in WAIT, SHALL set err_timeout, update last_grant, leave out_seq unchanged, and return to IDLE.
REQ-026 SHALL ignore core_done outside WAIT.
REQ-027 If core_done and the timeout occur in the same cycle, core_done SHALL take priority (no error).
REQ-028 A new grant SHALL take effect no earlier than the cycle after WAIT exits, so that streams never overlap.
REQ-029 SHALL clear err_timeout only on rst.

Reset
REQ-030 On rst, SHALL set state=IDLE, last_grant=1 (so channel 0 wins the first tie), counters=0, out_seq=0, and all outputs=0, with s_ready=2'b00.
REQ-031 rst asserted mid-STREAM or mid-WAIT SHALL abort the frame with no out_valid emitted; the core SHALL receive core_clr at the next grant.

Structure
REQ-032 SHALL place state encoding, FRAME_LEN and the sample width (8) in the shared package fft_pkg.
REQ-033 SHALL keep round-robin selection as sub-module rr_arb2 (2 requests, last-grant input, one-hot grant output); all other logic SHALL stay flat.

Verification
REQ-034 Channel 0 only, samples (100,0), (71,71), (0,100), (-71,71), core_done 3 cycles after the 4th strobe -> exactly 4 core_valid_in strobes with that data, one core_clr, and out_valid with out_ch=0, out_seq=0.
REQ-035 Both s_valid held high for 3 frames -> grants 0,1,0; out_seq 0,1,2; s_ready never 2'b11.
REQ-036 Channel 1 with a gap after sample 2 (s_valid low for 5 cycles) -> no extra strobes, frame completes, no err_timeout.
REQ-037 core_done withheld -> err_timeout=1 exactly TIMEOUT_CYC=16 cycles after WAIT entry, no out_valid, and the next frame proceeds normally.
REQ-038 rst pulsed after the 2nd sample -> outputs zero, and the next frame starts with core_clr and out_seq=0.
REQ-039 core_done pulsed in IDLE and STREAM -> no out_valid.
